// File: rtl/tsn_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tsn_gate_ctrl
// Brief   : Cyclic gate control list sequencer producing per-queue eligibility.
//           Optional guard band selected with `GCM_GUARD_BAND_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tsn_gate_ctrl #(
  parameter int GCL_DEPTH    = 8,
  parameter int GCL_AW       = 3,
  parameter int TIME_W       = 32,
  parameter int GUARD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_gcm_enable,
  input  logic              in_gcm_cfg_wr,
  input  logic [GCL_AW-1:0] in_gcm_cfg_addr,
  input  logic [7:0]        in_gcm_cfg_gate,
  input  logic [TIME_W-1:0] in_gcm_cfg_interval,
  input  logic              in_gcm_cfg_len_wr,
  input  logic [GCL_AW:0]   in_gcm_cfg_len,
  input  logic [7:0]        in_gcm_queue_nempty,
  output logic [7:0]        out_gcm_valid,
  output logic [7:0]        out_gcm_gate_state,
  output logic [GCL_AW-1:0] out_gcm_entry_idx,
  output logic              out_gcm_cycle_start
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [GCL_AW:0] DEPTH_C = (GCL_AW+1)'(GCL_DEPTH);
  localparam logic [GCL_AW:0] ONE_C   = (GCL_AW+1)'(1);

  state_t              state_q, state_d;
  logic [7:0]          gate_mem_q [GCL_DEPTH];
  logic [7:0]          gate_mem_d [GCL_DEPTH];
  logic [TIME_W-1:0]   ivl_mem_q  [GCL_DEPTH];
  logic [TIME_W-1:0]   ivl_mem_d  [GCL_DEPTH];
  logic [GCL_AW:0]     len_q, len_d;
  logic [TIME_W-1:0]   cnt_q, cnt_d;
  logic [7:0]          gate_state_q, gate_state_d;
  logic [GCL_AW-1:0]   idx_q, idx_d;
  logic                cycle_start_q, cycle_start_d;
  logic [7:0]          valid_q, valid_d;

  logic [GCL_AW-1:0]   next_idx;
  logic [TIME_W-1:0]   first_cnt;
  logic [TIME_W-1:0]   next_cnt;
  logic [7:0]          guard_mask;

  // Wrap when the following entry would fall outside the current list length;
  // this also covers a length that shrank below the running index.
  assign next_idx  = (({1'b0, idx_q} + ONE_C) >= len_q) ? '0 : idx_q + 1'b1;
  // A zero interval behaves as one cycle, so the loaded count saturates at 0.
  assign first_cnt = (ivl_mem_q[0] == '0) ? '0 : ivl_mem_q[0] - 1'b1;
  assign next_cnt  = (ivl_mem_q[next_idx] == '0) ? '0 : ivl_mem_q[next_idx] - 1'b1;

`ifdef GCM_GUARD_BAND_EN
  localparam logic [TIME_W-1:0] GUARD_C = TIME_W'(GUARD_CYCLES);
  assign guard_mask = ((state_q == S_RUN) && (cnt_q < GUARD_C)) ? gate_mem_q[next_idx] : 8'hFF;
`else
  logic [31:0] unused_guard;
  assign unused_guard = 32'(GUARD_CYCLES);
  assign guard_mask   = 8'hFF;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gate_state_d  = gate_state_q;
    idx_d         = idx_q;
    cycle_start_d = 1'b0;
    gate_mem_d    = gate_mem_q;
    ivl_mem_d     = ivl_mem_q;
    len_d         = len_q;
    valid_d       = gate_state_q & in_gcm_queue_nempty & guard_mask;

    case (state_q)
      S_IDLE: begin
        gate_state_d = '0;
        idx_d        = '0;
        cnt_d        = '0;
        if (in_gcm_enable) begin
          state_d       = S_RUN;
          gate_state_d  = gate_mem_q[0];
          cnt_d         = first_cnt;
          cycle_start_d = 1'b1;
        end
      end
      S_RUN: begin
        if (!in_gcm_enable) begin
          state_d      = S_IDLE;
          gate_state_d = '0;
          idx_d        = '0;
          cnt_d        = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          idx_d         = next_idx;
          gate_state_d  = gate_mem_q[next_idx];
          cnt_d         = next_cnt;
          cycle_start_d = (next_idx == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Entries are copied into gate_state/cnt at load time, so rewriting the
    // live entry cannot disturb the interval already in progress.
    if (in_gcm_cfg_wr && ({1'b0, in_gcm_cfg_addr} < DEPTH_C)) begin
      gate_mem_d[in_gcm_cfg_addr] = in_gcm_cfg_gate;
      ivl_mem_d[in_gcm_cfg_addr]  = in_gcm_cfg_interval;
    end
    if (in_gcm_cfg_len_wr) begin
      if (in_gcm_cfg_len == '0)         len_d = ONE_C;
      else if (in_gcm_cfg_len > DEPTH_C) len_d = DEPTH_C;
      else                               len_d = in_gcm_cfg_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      gate_state_q  <= '0;
      idx_q         <= '0;
      cycle_start_q <= 1'b0;
      valid_q       <= '0;
      len_q         <= ONE_C;
      for (int i = 0; i < GCL_DEPTH; i++) begin
        gate_mem_q[i] <= 8'hFF;
        ivl_mem_q[i]  <= TIME_W'(1);
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gate_state_q  <= gate_state_d;
      idx_q         <= idx_d;
      cycle_start_q <= cycle_start_d;
      valid_q       <= valid_d;
      len_q         <= len_d;
      gate_mem_q    <= gate_mem_d;
      ivl_mem_q     <= ivl_mem_d;
    end
  end

  assign out_gcm_valid       = valid_q;
  assign out_gcm_gate_state  = gate_state_q;
  assign out_gcm_entry_idx   = idx_q;
  assign out_gcm_cycle_start = cycle_start_q;

endmodule
`default_nettype wire

// File: tb/tb_tsn_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_tsn_gate_ctrl
// Brief   : Randomised and directed bench for tsn_gate_ctrl against a list-level
//           reference model (entry age vs. duration). Honours `GCM_GUARD_BAND_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tsn_gate_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TW    = 32;
  localparam int GUARD = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          wr;
  logic [AW-1:0] addr;
  logic [7:0]    gate;
  logic [TW-1:0] ivl;
  logic          len_wr;
  logic [AW:0]   len;
  logic [7:0]    nempty;
  logic [7:0]    valid;
  logic [7:0]    gate_state;
  logic [AW-1:0] idx;
  logic          cstart;

  tsn_gate_ctrl #(
    .GCL_DEPTH(DEPTH), .GCL_AW(AW), .TIME_W(TW), .GUARD_CYCLES(GUARD)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_gcm_enable      (en),
    .in_gcm_cfg_wr      (wr),
    .in_gcm_cfg_addr    (addr),
    .in_gcm_cfg_gate    (gate),
    .in_gcm_cfg_interval(ivl),
    .in_gcm_cfg_len_wr  (len_wr),
    .in_gcm_cfg_len     (len),
    .in_gcm_queue_nempty(nempty),
    .out_gcm_valid      (valid),
    .out_gcm_gate_state (gate_state),
    .out_gcm_entry_idx  (idx),
    .out_gcm_cycle_start(cstart)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: the list as plain arrays, the running entry tracked by
  // how many cycles it has been shown (age) against its effective duration.
  int m_gate [DEPTH];
  int m_int  [DEPTH];
  int m_len, m_idx, m_age, m_dur, m_gs, m_valid;
  bit m_run, m_cs;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_gate[i] = 8'hFF;
      m_int[i]  = 1;
    end
    m_len = 1; m_idx = 0; m_age = 0; m_dur = 1;
    m_gs = 0; m_valid = 0; m_run = 0; m_cs = 0;
  endfunction

  function automatic int following();
    return (m_idx + 1 >= m_len) ? 0 : m_idx + 1;
  endfunction

  function automatic void enter(input int e);
    m_idx = e;
    m_gs  = m_gate[e];
    m_dur = (m_int[e] < 1) ? 1 : m_int[e];
    m_age = 1;
    m_cs  = (e == 0);
  endfunction

  function automatic void model_step();
    int mask = 8'hFF;
`ifdef GCM_GUARD_BAND_EN
    if (m_run && (m_dur - m_age) < GUARD) mask = m_gate[following()];
`endif
    m_valid = m_gs & int'(nempty) & mask;
    m_cs = 0;
    if (!en) begin
      m_run = 0; m_gs = 0; m_idx = 0;
    end else if (!m_run) begin
      m_run = 1;
      enter(0);
    end else if (m_age < m_dur) begin
      m_age++;
    end else begin
      enter(following());
    end
    if (wr && int'(addr) < DEPTH) begin
      m_gate[addr] = int'(gate);
      m_int[addr]  = int'(ivl);
    end
    if (len_wr) m_len = (len == 0) ? 1 : (int'(len) > DEPTH) ? DEPTH : int'(len);
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    @(negedge clk);
    check_eq("gate_state",  32'(gate_state), 32'(m_gs));
    check_eq("entry_idx",   32'(idx),        32'(m_idx));
    check_eq("cycle_start", 32'(cstart),     32'(m_cs));
    check_eq("valid",       32'(valid),      32'(m_valid));
    wr = 1'b0;
    len_wr = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr_entry(input int a, input int g, input int iv);
    addr = AW'(a); gate = 8'(g); ivl = TW'(iv); wr = 1'b1;
    cyc();
  endtask

  task automatic wr_len(input int l);
    len = (AW+1)'(l); len_wr = 1'b1;
    cyc();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_valid",  32'(valid),      32'h0);
    check_eq("rst_gate",   32'(gate_state), 32'h0);
    check_eq("rst_idx",    32'(idx),        32'h0);
    check_eq("rst_cstart", 32'(cstart),     32'h0);
    model_reset();
    @(negedge clk);
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; wr = 1'b0; addr = '0; gate = '0; ivl = '0;
    len_wr = 1'b0; len = '0; nempty = '0;
    model_reset();
    run(2);
    rst_n = 1'b1;
    run(2);

    // Default list: all gates open, one-cycle entry repeating.
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      nempty = 8'($urandom);
      cyc();
    end

    // Three-entry list, including a zero interval.
    en = 1'b0;
    cyc();
    wr_entry(0, 8'h01, 5);
    wr_entry(1, 8'h02, 3);
    wr_entry(2, 8'h80, 0);
    wr_len(3);
    en = 1'b1; nempty = 8'h03;
    run(20);
    for (int i = 0; i < 20 && m_idx != 1; i++) cyc();
    check_eq("reach_entry1", 32'(m_idx), 32'd1);
    wr_entry(1, 8'h04, 2);
    run(25);
    wr_len(1);
    run(10);

    // Enable dropped mid-entry, re-raised four cycles later.
    wr_len(3);
    run(7);
    en = 1'b0;
    run(4);
    en = 1'b1;
    run(12);

    async_reset();
    en = 1'b1;
    run(5);

    // Guard band scenario.
    en = 1'b0;
    cyc();
    wr_entry(0, 8'h03, 6);
    wr_entry(1, 8'h01, 4);
    wr_len(2);
    en = 1'b1; nempty = 8'hFF;
    run(25);

    for (int i = 0; i < 3000; i++) begin
      en     = ($urandom_range(0, 49) != 0);
      nempty = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        addr = AW'($urandom); gate = 8'($urandom); ivl = TW'($urandom_range(0, 5));
        wr = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) begin
        len = (AW+1)'($urandom_range(0, 15)); len_wr = 1'b1;
      end
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end else begin
        cyc();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tsn_gate_ctrl.md
# tsn_gate_ctrl

Gate control stage feeding the priority scheduler. It runs a cyclic gate control list (GCL) of up to `GCL_DEPTH` entries. Each entry holds an 8-bit gate mask and a duration in clock cycles. Each cycle the block drives the per-queue eligibility vector, `out_gcm_valid` = open gates ANDed with the queue-non-empty flags, to the scheduler. The GCL is written through a simple configuration port owned by the local control module.

## Interface
- `GCL_DEPTH`, 8: number of GCL entries.
- `GCL_AW`, 3: GCL address width, log2(`GCL_DEPTH`).
- `TIME_W`, 32: entry interval width, in cycles.
- `GUARD_CYCLES`, 16: guard-band length; used only with `GCM_GUARD_BAND_EN`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_gcm_enable` in 1: run the GCL (test start from LCM).
- `in_gcm_cfg_wr` in 1: single-cycle GCL entry write strobe.
- `in_gcm_cfg_addr` in `GCL_AW`: entry address.
- `in_gcm_cfg_gate` in 8: gate mask; bit i = queue i open.
- `in_gcm_cfg_interval` in `TIME_W`: entry duration in cycles.
- `in_gcm_cfg_len_wr` in 1: list-length write strobe.
- `in_gcm_cfg_len` in `GCL_AW`+1: active entry count.
- `in_gcm_queue_nempty` in 8: per-queue non-empty flags.
- `out_gcm_valid` out 8: eligible queues, to TSM.
- `out_gcm_gate_state` out 8: current gate mask.
- `out_gcm_entry_idx` out `GCL_AW`: current entry index.
- `out_gcm_cycle_start` out 1: one-cycle pulse when entry 0 is loaded.

## Operation
- Reset values:
  - All outputs 0.
  - Every GCL entry: gate = 8'hFF, interval = 1.
  - Length = 1.
  - Down-counter = 0.
  - State IDLE.
- GCL storage is a register array with combinational read, so the next entry is always available without prefetch latency.
- Config writes are accepted in any state.
  - A write to an entry takes effect the next time that entry is loaded; an entry currently in use is not altered mid-interval.
  - Length is clamped: 0 becomes 1, and values above `GCL_DEPTH` become `GCL_DEPTH`.
  - A length change is applied at the next entry boundary.
  - A write with addr ≥ `GCL_DEPTH` is ignored.
- Interval 0 is treated as 1.
- State machine (2 states):
  - IDLE: gate_state = 0, idx = 0. When `in_gcm_enable` = 1, load entry 0 (gate_state, cnt = interval−1), pulse `out_gcm_cycle_start`, and go to RUN.
  - RUN:
    - If `in_gcm_enable` = 0, go to IDLE; gate_state and idx are cleared on the same edge.
    - Else if cnt ≠ 0, decrement cnt.
    - Else advance idx to next = (idx = len−1) ? 0 : idx+1, load gate_state/cnt from entry[next], and pulse `out_gcm_cycle_start` iff next = 0.
- If the length shrinks so that idx ≥ new len−1 at the boundary, next = 0.
- `out_gcm_valid` is a register updated every cycle from `out_gcm_gate_state` AND `in_gcm_queue_nempty`, after the optional guard mask.

## Timing
- `in_gcm_enable` rises, sampled at edge T:
  - gate_state, idx, and cycle_start are valid after T+1.
  - `out_gcm_valid` reflects them after T+2.
- Entry k drives `out_gcm_gate_state` for exactly max(interval_k, 1) cycles, back to back, with no gap cycle between entries.
- Full GCL period = Σ max(interval_i, 1) cycles; `out_gcm_cycle_start` repeats with exactly this period.
- Latency from `in_gcm_queue_nempty` to `out_gcm_valid`: 1 cycle.
- Enable dropping, sampled at edge T: gate_state = 0 after T+1; `out_gcm_valid` = 0 after T+2.
- A config write at edge T to the entry loaded at the same edge T: the old value is used.
- Asynchronous reset mid-list: all state returns to reset values immediately. The GCL contents are also reset.

## Configuration
- `GCM_GUARD_BAND_EN` defined:
  - While in RUN with cnt < `GUARD_CYCLES`, queues open now but closed in entry[next] are masked.
  - out_valid = gate_state & entry[next].gate & nempty.
  - This prevents a frame from starting that would overrun the gate close.
  - When `GUARD_CYCLES` ≥ the interval, the mask applies for the whole entry.
- Not defined: out_valid = gate_state & nempty, and `GUARD_CYCLES` is unused.

## Test plan
- Reset, enable held at 1 with default GCL → gate_state = 8'hFF continuously; cycle_start pulses every cycle; valid = nempty delayed by 1 cycle.
- Program len = 3: {8'h01, 5}, {8'h02, 3}, {8'h80, 0}; enable → gate pattern 01×5, 02×3, 80×1 repeating; cycle_start period 9; idx sequence 0, 1, 2.
- nempty = 8'h03 during the above → valid = 01, 02, 00 phases, each shifted 1 cycle from gate_state.
- Rewrite entry 1 to {8'h04, 2} while entry 1 is active → the current entry finishes with 02×3; the next list pass shows 04×2. Change len to 1 mid-list → wraps to entry 0 at the next boundary.
- Drop enable mid-entry, re-raise 4 cycles later → gate_state = 0 one cycle after the drop; the restart begins at entry 0 with a cycle_start pulse. Assert rst_n low mid-run → all outputs 0 immediately.
- With `GCM_GUARD_BAND_EN`, `GUARD_CYCLES` = 2, entries {8'h03, 6}, {8'h01, 4}, nempty = 8'hFF → valid = 03 for the first 4 cycles and 01 for the last 2 cycles of entry 0; without the macro, valid = 03 for all 6 cycles.
